// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package instruction_fetch_unit_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    // Byte distance between consecutive instruction words
    localparam int unsigned PC_INCREMENT = 4;

    // First fetch address after reset
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// rtl/instruction_fetch_unit_fetch_fifo.sv - {PC, instruction} buffer between fetch and decode
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   push, push_pc,        write one entry at the tail
//   push_instr
//   pop                   remove the head entry (caller guarantees count > 0)
//   clear                 drop every entry; wins over push and pop
//   head_pc, head_instr   head entry, or the last presented entry while empty
//   count                 number of buffered entries
module fetch_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_pc,
    input  logic [DATA_WIDTH-1:0] push_instr,
    input  logic                  pop,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] head_pc,
    output logic [DATA_WIDTH-1:0] head_instr,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [DATA_WIDTH-1:0] hold_pc;
    logic [DATA_WIDTH-1:0] hold_instr;
    logic                  not_empty;

    assign not_empty = (count != '0);

    // Storage carries no reset; the hold registers cover reads while empty.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Remember whatever is on the outputs so they stay put once the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_pc    <= '0;
            hold_instr <= '0;
        end else if (not_empty) begin
            hold_pc    <= pc_mem[rd_ptr];
            hold_instr <= instr_mem[rd_ptr];
        end
    end

    assign head_pc    = not_empty ? pc_mem[rd_ptr]    : hold_pc;
    assign head_instr = not_empty ? instr_mem[rd_ptr] : hold_instr;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC sequencer and fetch FSM feeding a decode-side FIFO
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   Mem_Address_o         fetch address (always the PC register)
//   Mem_Instruction_i     instruction word for Mem_Address_o, same cycle
//   Branch_Taken_i,       redirect request and its target
//   Branch_Target_i
//   Ready_i               decode accepts the presented entry
//   Valid_o, Instruction_o, PC_o   FIFO head entry
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] Mem_Address_o,
    input  logic [DATA_WIDTH-1:0] Mem_Instruction_i,
    input  logic                  Branch_Taken_i,
    input  logic [DATA_WIDTH-1:0] Branch_Target_i,
    input  logic                  Ready_i,
    output logic                  Valid_o,
    output logic [DATA_WIDTH-1:0] Instruction_o,
    output logic [DATA_WIDTH-1:0] PC_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e          state;
    fetch_state_e          state_next;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0] branch_pc;
    logic [CNT_W-1:0]      count;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic                  redirect;

    assign Mem_Address_o = pc;
    assign Valid_o       = (count != '0);
    assign fifo_full     = (count == CNT_W'(FIFO_DEPTH));
    assign pop           = Valid_o && Ready_i;

    // A redirect never pushes; a full FIFO takes a push only alongside a pop.
    assign push     = (state == ST_RUN) && !Branch_Taken_i && (!fifo_full || pop);
    assign redirect = Branch_Taken_i && (state != ST_IDLE);

    // Instruction words are aligned: the low two target bits are dropped.
    assign branch_pc = Branch_Target_i & ~DATA_WIDTH'(3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            ST_IDLE: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (Branch_Taken_i) begin
                    state_next = ST_FLUSH;
                    pc_next    = branch_pc;
                end else if (push) begin
                    pc_next = pc + DATA_WIDTH'(PC_INCREMENT);
                end
            end
            ST_FLUSH: begin
                // A second redirect retargets and spends another bubble cycle.
                if (Branch_Taken_i) begin
                    pc_next = branch_pc;
                end else begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // clear outranks the simultaneous pop, so the popped entry is consumed and the rest discarded.
    fetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push       (push),
        .push_pc    (pc),
        .push_instr (Mem_Instruction_i),
        .pop        (pop),
        .clear      (redirect),
        .head_pc    (PC_o),
        .head_instr (Instruction_o),
        .count      (count)
    );

endmodule
